// File: rtl/wb_spi_master_if.sv
// Wishbone slave bus and SPI pins of wb_spi_master.
// The master modport belongs to the CPU side together with the SPI peripheral that drives miso.
`timescale 1ns/1ps
interface wb_spi_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wbs_address;
    logic [DATA_WIDTH-1:0] wbs_writedata;
    logic [DATA_WIDTH-1:0] wbs_readdata;
    logic                  wbs_strobe;
    logic                  wbs_cycle;
    logic                  wbs_write;
    logic                  wbs_ack;
    logic                  sclk;
    logic                  ss;
    logic                  mosi;
    logic                  miso;
    logic                  spi_done;

    modport master (
        output wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write, miso,
        input  wbs_readdata, wbs_ack, sclk, ss, mosi, spi_done
    );

    modport slave (
        input  wbs_address, wbs_writedata, wbs_strobe, wbs_cycle, wbs_write, miso,
        output wbs_readdata, wbs_ack, sclk, ss, mosi, spi_done
    );
endinterface

// File: rtl/wb_spi_master.sv
// Mode-0 SPI byte master behind a Wishbone slave; ack on the 2nd strobe cycle, transfer busy 18*CLK_DIV clks.
// No backpressure: a TXDATA write while busy is dropped and flagged as overrun.
`timescale 1ns/1ps
module wb_spi_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic           clk,
    input  logic           reset,
    wb_spi_master_if.slave bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;
    state_t r_state, w_state_nxt;

    logic                  r_stb_d;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic [DATA_WIDTH-1:0] w_rd_mux;
    logic [7:0]            r_tx, r_rx, r_rx_data;
    logic [1:0]            r_ctrl;
    logic                  r_done, r_ovr, r_hold_act;
    logic                  r_sclk, r_mosi, r_spi_done;
    logic [DIV_W-1:0]      r_div;
    logic [2:0]            r_bit;
    logic [2:0]            w_nxt_idx;
    logic [1:0]            w_reg;
    logic                  w_ack, w_acc, w_tick, w_busy, w_ss;
    logic                  w_tx_wr, w_ctrl_wr, w_stat_rd;
    logic                  w_unused;

    assign w_reg     = bus.wbs_address[3:2];
    assign w_ack     = bus.wbs_strobe & r_stb_d;
    assign w_acc     = w_ack & bus.wbs_cycle;
    assign w_tx_wr   = w_acc & bus.wbs_write & (w_reg == 2'd0);
    assign w_ctrl_wr = w_acc & bus.wbs_write & (w_reg == 2'd3);
    assign w_stat_rd = w_acc & ~bus.wbs_write & (w_reg == 2'd2);
    assign w_busy    = (r_state != S_IDLE);
    assign w_tick    = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_nxt_idx = r_ctrl[0] ? (3'd6 - r_bit) : (r_bit + 3'd1);
    assign w_unused  = &{1'b0, bus.wbs_address, bus.wbs_writedata};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ss        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ss = ~r_hold_act;
                if (w_tx_wr) w_state_nxt = S_SETUP;
            end
            S_SETUP: if (w_tick) w_state_nxt = S_SHIFT;
            // the 8th falling edge is a tick while sclk is high on the last bit
            S_SHIFT: if (w_tick && r_sclk && (r_bit == 3'd7)) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_reg)
            2'd0:    w_rd_mux[7:0] = r_tx;
            2'd1:    w_rd_mux[7:0] = r_rx_data;
            2'd2:    w_rd_mux[2:0] = {r_ovr, r_done, w_busy};
            default: w_rd_mux[1:0] = r_ctrl;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stb_d    <= 1'b0;
            r_readdata <= '0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_rx_data  <= 8'h00;
            r_ctrl     <= 2'b01;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_hold_act <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_spi_done <= 1'b0;
            r_div      <= '0;
            r_bit      <= 3'd0;
        end else begin
            r_stb_d    <= bus.wbs_strobe;
            r_spi_done <= 1'b0;
            if (bus.wbs_strobe && bus.wbs_cycle && !bus.wbs_write) r_readdata <= w_rd_mux;

            if (w_ctrl_wr && !w_busy) begin
                r_ctrl <= bus.wbs_writedata[1:0];
                if (!bus.wbs_writedata[1]) r_hold_act <= 1'b0;
            end

            // clears first so that a coinciding set event wins
            if (w_stat_rd) begin
                r_done <= 1'b0;
                r_ovr  <= 1'b0;
            end
            if (w_tx_wr && w_busy) r_ovr <= 1'b1;

            if (w_tx_wr && !w_busy) begin
                r_tx   <= bus.wbs_writedata[7:0];
                r_done <= 1'b0;
                r_mosi <= r_ctrl[0] ? bus.wbs_writedata[7] : bus.wbs_writedata[0];
                r_sclk <= 1'b0;
                r_bit  <= 3'd0;
                r_div  <= '0;
            end else if (w_busy) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end

            if ((r_state == S_SHIFT) && w_tick) begin
                r_sclk <= ~r_sclk;
                if (!r_sclk) begin
                    r_rx <= r_ctrl[0] ? {r_rx[6:0], bus.miso} : {bus.miso, r_rx[7:1]};
                end else if (r_bit != 3'd7) begin
                    r_bit  <= r_bit + 3'd1;
                    r_mosi <= r_tx[w_nxt_idx];
                end
            end

            if ((r_state == S_HOLD) && w_tick) begin
                r_rx_data  <= r_rx;
                r_done     <= 1'b1;
                r_spi_done <= 1'b1;
                if (r_ctrl[1]) r_hold_act <= 1'b1;
            end
        end
    end

    assign bus.wbs_ack      = w_ack;
    assign bus.wbs_readdata = r_readdata;
    assign bus.sclk         = r_sclk;
    assign bus.ss           = w_ss;
    assign bus.mosi         = r_mosi;
    assign bus.spi_done     = r_spi_done;
endmodule
